// File: rtl/bus_regfile_pkg.sv
// Shared defaults, cell operation encoding and the clog2 helper for bus_regfile.
package bus_regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    CELL_HOLD,
    CELL_LOAD,
    CELL_INC
  } cell_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_reg_cell.sv
// Single register cell: clear > load > increment, with a one-cycle wrap flag.
module bus_reg_cell
  import bus_regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  cell_op_e op;

  always_comb begin
    op = CELL_HOLD;
    if (load) begin
      op = CELL_LOAD;
    end else if (inc) begin
      op = CELL_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (op)
        CELL_LOAD: q <= d;
        CELL_INC: begin
          q    <= q + WIDTH'(1);
          wrap <= &q;
        end
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/bus_regfile.sv
// Register file with write, increment and a registered read bus.
// Define BUS_REGFILE_BYPASS_EN to forward same-edge write/increment data to the read bus.
module bus_regfile
  import bus_regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          din,
  input  logic                      inc,
  input  logic [clog2(DEPTH)-1:0]   iaddr,
  input  logic                      oe,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic                      carry
);

  localparam int unsigned ADDR_W = clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] loads;
  logic [DEPTH-1:0] incs;
  logic [DEPTH-1:0] wraps;
  logic [WIDTH-1:0] rdata;

  // A write to the same register suppresses its increment.
  always_comb begin
    loads = '0;
    incs  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      loads[i] = we && (waddr == ADDR_W'(i));
      incs[i]  = inc && (iaddr == ADDR_W'(i)) && !loads[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    bus_reg_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .load(loads[g]),
      .inc (incs[g]),
      .d   (din),
      .q   (regs[g]),
      .wrap(wraps[g])
    );
  end

  assign carry = |wraps;

  always_comb begin
    rdata = regs[raddr];
`ifdef BUS_REGFILE_BYPASS_EN
    if (we && (raddr == waddr)) begin
      rdata = din;
    end else if (inc && (raddr == iaddr)) begin
      rdata = regs[iaddr] + WIDTH'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= oe ? rdata : '0;
      dout_valid <= oe;
    end
  end

endmodule

// File: tb/tb_bus_regfile.sv
// Scoreboard-driven self-checking bench for bus_regfile (default 8x4 configuration).
module tb_bus_regfile;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;

  typedef struct {
    logic [W-1:0] dout;
    logic         valid;
    logic         carry;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, we, inc, oe;
  logic [AW-1:0] waddr, iaddr, raddr;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          dout_valid, carry;

  logic [W-1:0]  model [D];
  exp_t          sb [$];
  exp_t          e;
  int            total = 0;
  int            bad = 0;

  bus_regfile #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .din(din),
    .inc(inc), .iaddr(iaddr), .oe(oe), .raddr(raddr),
    .dout(dout), .dout_valid(dout_valid), .carry(carry)
  );

  always #5 clk = ~clk;

  // Drive one cycle, predict the outputs visible after the edge, then advance.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] wa, input logic [W-1:0] d,
                      input logic i, input logic [AW-1:0] ia, input logic o, input logic [AW-1:0] ra);
    exp_t x;
    logic [W-1:0] rd;
    logic collide;
    rst = r; we = w; waddr = wa; din = d; inc = i; iaddr = ia; oe = o; raddr = ra;
    collide = w && (wa == ia);
    if (r) begin
      x.dout = '0; x.valid = 1'b0; x.carry = 1'b0;
    end else begin
      rd = model[ra];
`ifdef BUS_REGFILE_BYPASS_EN
      if (w && ra == wa) rd = d;
      else if (i && ra == ia) rd = model[ia] + 8'd1;
`endif
      x.dout  = o ? rd : '0;
      x.valid = o;
      x.carry = i && !collide && (model[ia] == 8'hFF);
    end
    sb.push_back(x);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < D; k++) model[k] = '0;
    end else begin
      if (i && !collide) model[ia] = model[ia] + 8'd1;
      if (w) model[wa] = d;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 8'h5A, 1, 1, 1, 0);
    e = sb.pop_front(); total++;
    if (dout !== e.dout || dout_valid !== e.valid || carry !== e.carry) begin
      bad++; $display("FAIL reset_state: got %h/%b/%b want %h/%b/%b", dout, dout_valid, carry, e.dout, e.valid, e.carry);
    end
    for (int a = 0; a < D; a++) begin
      step(0, 0, 0, 0, 0, 0, 1, AW'(a));
      e = sb.pop_front(); total++;
      if (dout !== 8'h00 || dout_valid !== 1'b1 || carry !== 1'b0 || dout !== e.dout) begin
        bad++; $display("FAIL reset_read r%0d: got %h/%b/%b want 00/1/0", a, dout, dout_valid, carry);
      end
    end
  endtask

  task automatic test_write_read();
    step(0, 1, 2, 8'hA5, 0, 0, 0, 0);
    e = sb.pop_front(); total++;
    if (dout !== e.dout || dout_valid !== e.valid || carry !== e.carry) begin
      bad++; $display("FAIL write_idle: got %h/%b/%b want %h/%b/%b", dout, dout_valid, carry, e.dout, e.valid, e.carry);
    end
    step(0, 0, 0, 0, 0, 0, 1, 2);
    e = sb.pop_front(); total++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1 || dout !== e.dout) begin
      bad++; $display("FAIL read_r2: got %h/%b want a5/1", dout, dout_valid);
    end
    step(0, 0, 0, 0, 0, 0, 0, 2);
    e = sb.pop_front(); total++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || dout !== e.dout) begin
      bad++; $display("FAIL release_bus: got %h/%b want 00/0", dout, dout_valid);
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 1, 8'hFF, 0, 0, 0, 0);
    void'(sb.pop_front());
    step(0, 0, 0, 0, 1, 1, 0, 0);
    e = sb.pop_front(); total++;
    if (carry !== 1'b1 || carry !== e.carry) begin
      bad++; $display("FAIL wrap_carry: got %b want 1", carry);
    end
    step(0, 0, 0, 0, 1, 1, 1, 1);
    e = sb.pop_front(); total++;
    if (carry !== 1'b0 || dout !== e.dout || dout_valid !== e.valid) begin
      bad++; $display("FAIL second_inc: got %h/%b/%b want %h/%b/0", dout, dout_valid, carry, e.dout, e.valid);
    end
    step(0, 0, 0, 0, 0, 0, 1, 1);
    e = sb.pop_front(); total++;
    if (dout !== 8'h01 || carry !== 1'b0 || dout !== e.dout) begin
      bad++; $display("FAIL r1_after_incs: got %h/%b want 01/0", dout, carry);
    end
  endtask

  task automatic test_collide();
    logic [W-1:0] want [3];
    logic [AW-1:0] addr [3];
    step(0, 1, 1, 8'h05, 0, 0, 0, 0);
    void'(sb.pop_front());
    step(0, 1, 3, 8'h10, 1, 3, 0, 0);
    e = sb.pop_front(); total++;
    if (carry !== 1'b0 || carry !== e.carry) begin
      bad++; $display("FAIL collide_carry: got %b want 0", carry);
    end
    step(0, 1, 0, 8'h10, 1, 1, 0, 0);
    void'(sb.pop_front());
    want = '{8'h10, 8'h10, 8'h06};
    addr = '{2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 1, addr[k]);
      e = sb.pop_front(); total++;
      if (dout !== want[k] || dout !== e.dout || dout_valid !== 1'b1) begin
        bad++; $display("FAIL collide_r%0d: got %h want %h", addr[k], dout, want[k]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] want;
    step(0, 1, 2, 8'h11, 0, 0, 0, 0);
    void'(sb.pop_front());
`ifdef BUS_REGFILE_BYPASS_EN
    want = 8'h3C;
`else
    want = 8'h11;
`endif
    step(0, 1, 2, 8'h3C, 0, 0, 1, 2);
    e = sb.pop_front(); total++;
    if (dout !== want || dout !== e.dout) begin
      bad++; $display("FAIL write_bypass: got %h want %h", dout, want);
    end
`ifdef BUS_REGFILE_BYPASS_EN
    want = 8'h3D;
`else
    want = 8'h3C;
`endif
    step(0, 0, 0, 0, 1, 2, 1, 2);
    e = sb.pop_front(); total++;
    if (dout !== want || dout !== e.dout) begin
      bad++; $display("FAIL inc_bypass: got %h want %h", dout, want);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, 8'h77, 0, 0, 0, 0);
    void'(sb.pop_front());
    step(0, 0, 0, 0, 0, 0, 1, 0);
    e = sb.pop_front(); total++;
    if (dout !== 8'h77 || dout !== e.dout) begin
      bad++; $display("FAIL preload_r0: got %h want 77", dout);
    end
    step(1, 1, 1, 8'h99, 1, 2, 1, 0);
    e = sb.pop_front(); total++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || carry !== 1'b0 || dout !== e.dout) begin
      bad++; $display("FAIL mid_reset: got %h/%b/%b want 00/0/0", dout, dout_valid, carry);
    end
    for (int a = 0; a < D; a++) begin
      step(0, 0, 0, 0, 0, 0, 1, AW'(a));
      e = sb.pop_front(); total++;
      if (dout !== 8'h00 || dout_valid !== 1'b1 || dout !== e.dout) begin
        bad++; $display("FAIL post_reset_r%0d: got %h/%b want 00/1", a, dout, dout_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic r;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 39) == 0);
      step(r, 1'($urandom), AW'($urandom), (($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom)),
           ($urandom_range(0, 2) != 0), AW'($urandom), ($urandom_range(0, 4) != 0), AW'($urandom));
      e = sb.pop_front(); total++;
      if (dout !== e.dout || dout_valid !== e.valid || carry !== e.carry) begin
        bad++; $display("FAIL random_cycle%0d: got %h/%b/%b want %h/%b/%b", n, dout, dout_valid, carry, e.dout, e.valid, e.carry);
      end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; inc = 1'b0; oe = 1'b0;
    waddr = '0; iaddr = '0; raddr = '0; din = '0;
    for (int k = 0; k < D; k++) model[k] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_wrap();
    test_collide();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_regfile.md
BUS_REGFILE -- requirements
Module: bus_regfile

Interface
REQ-001 Parameter WIDTH, default 8, data width of each register in bits; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 4, number of registers; SHALL be a power of two, at least 2.
REQ-003 Derived ADDR_W = clog2(DEPTH); SHALL NOT be overridable.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port we  input  1  write enable.
REQ-007 Port waddr  input  ADDR_W  write register select.
REQ-008 Port din  input  WIDTH  write data.
REQ-009 Port inc  input  1  increment enable.
REQ-010 Port iaddr  input  ADDR_W  increment register select.
REQ-011 Port oe  input  1  output enable, drives the bus.
REQ-012 Port raddr  input  ADDR_W  read register select.
REQ-013 Port dout  output  WIDTH  registered bus data.
REQ-014 Port dout_valid  output  1  dout carries register data this cycle.
REQ-015 Port carry  output  1  one-cycle pulse on increment wrap-around.

Function
REQ-016 All inputs SHALL be sampled on the rising clk edge; all state changes occur only on that edge.
REQ-017 we=1: reg[waddr] SHALL take din at the edge.
REQ-018 inc=1: reg[iaddr] SHALL take (reg[iaddr]+1) mod 2^WIDTH at the edge.
REQ-019 Increment from all-ones SHALL wrap to 0 and set carry=1 for exactly the next cycle; otherwise carry=0.
REQ-020 we=1, inc=1, waddr==iaddr: the write SHALL win; no increment; carry=0.
REQ-021 we=1, inc=1, waddr!=iaddr: both updates SHALL occur at the same edge.
REQ-022 oe=1: dout SHALL be reg[raddr] one cycle later, and dout_valid=1 in that cycle.
REQ-023 oe=0: dout SHALL be 0 and dout_valid=0 one cycle later, which releases the bus.
REQ-024 Read latency SHALL be exactly 1 cycle; back-to-back reads SHALL be supported every cycle.
REQ-025 With the bypass feature absent, a read of an address updated at the same edge SHALL return the pre-update value.
REQ-026 Registers not addressed by a write or increment SHALL hold their value.

Reset
REQ-027 rst=1 at an edge SHALL clear all registers, dout, dout_valid and carry to 0.
REQ-028 rst SHALL dominate we, inc and oe at the same edge; none of their effects occur.
REQ-029 The first edge with rst=0 SHALL operate normally.
REQ-030 Reset asserted mid-sequence SHALL abort any pending read result.

Configuration
REQ-031 Macro BUS_REGFILE_BYPASS_EN defined: a read with raddr==waddr and we=1 SHALL return din.
REQ-032 Macro BUS_REGFILE_BYPASS_EN defined: a read with raddr==iaddr, inc=1 and no winning write SHALL return the incremented value.
REQ-033 Macro BUS_REGFILE_BYPASS_EN undefined: REQ-025 behaviour applies.

Structure
REQ-034 Package bus_regfile_pkg SHALL hold the WIDTH and DEPTH default constants and the clog2 helper.
REQ-035 Sub-module bus_reg_cell SHALL implement one register with priority clear > load > increment and a wrap flag.
REQ-036 bus_regfile SHALL instantiate DEPTH cells and implement the address decode and the read and bypass mux.

Verification
REQ-037 Reset, then oe=1 with raddr=0..3 → dout=0x00 each cycle, dout_valid=1, carry=0.
REQ-038 Write 0xA5 to r2, then oe=1 with raddr=2 → next cycle dout=0xA5; oe=0 → dout=0x00, dout_valid=0.
REQ-039 Write 0xFF to r1, then inc r1 → r1=0x00, carry=1 for one cycle; inc again → r1=0x01, carry=0.
REQ-040 Same edge: we r3=0x10 and inc r3 → r3=0x10, carry=0; we r0=0x10 and inc r1 (r1=0x05) → r0=0x10, r1=0x06.
REQ-041 Same edge: we r2=0x3C with oe raddr=2 (r2 was 0x11) → dout=0x3C with macro, 0x11 without.
REQ-042 Load r0=0x77 and hold oe=1, then assert rst together with we and inc → next cycle all registers 0, dout=0, dout_valid=0, carry=0.
